complex_to_mag_axis: RTL and testbench

//  Multi-channel, pipelined successor to the single-lane IQ magnitude stage in the CSI extractor.

---
 rtl/complex_to_mag_pkg.sv | 20 ++
 rtl/complex_to_mag_lane.sv | 76 +++++++
 rtl/complex_to_mag_axis.sv | 125 ++++++++++++
 tb/tb_complex_to_mag_axis.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/complex_to_mag_pkg.sv
// Shared types for the multi-lane IQ magnitude pipeline: approximation modes
// and the per-stage sideband carried alongside each beat.
package complex_to_mag_pkg;

  typedef enum logic [1:0] {
    MAG_MODE_Q4   = 2'd0,
    MAG_MODE_Q38  = 2'd1,
    MAG_MODE_ACC  = 2'd2,
    MAG_MODE_RSVD = 2'd3
  } mag_mode_e;

  typedef struct packed {
    mag_mode_e mode;
    logic      last;
  } mag_sb_t;

  localparam int MAG_DEFAULT_DATA_WIDTH = 16;
  localparam int MAG_DEFAULT_NUM_CH     = 4;

endpackage

// File: rtl/complex_to_mag_lane.sv
// One lane of the alpha-max-beta-min datapath: S1 abs, S2 min/max, S3 combine.
// Stage enables come from the top; this block has no handshake of its own.
module complex_to_mag_lane
  import complex_to_mag_pkg::*;
#(
  parameter int DATA_WIDTH = MAG_DEFAULT_DATA_WIDTH
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  s1_en_in,
  input  logic                  s2_en_in,
  input  logic                  s3_en_in,
  input  logic [DATA_WIDTH-1:0] i_in,
  input  logic [DATA_WIDTH-1:0] q_in,
  input  logic [1:0]            mode_in,
  output logic [DATA_WIDTH:0]   mag_out
);

  localparam int OW = DATA_WIDTH + 1;

  logic [DATA_WIDTH-1:0] w_abs_i, w_abs_q;
  logic [DATA_WIDTH-1:0] r_abs_i, r_abs_q, r_max, r_min;
  logic [OW-1:0]         w_max, w_min, w_q4, w_q38, w_acc, w_acc_sel, w_mag, r_mag;

  // Two's-complement negate of the most negative code wraps to 2^(DW-1),
  // which is exactly right when read as unsigned.
  assign w_abs_i = i_in[DATA_WIDTH-1] ? (~i_in + DATA_WIDTH'(1)) : i_in;
  assign w_abs_q = q_in[DATA_WIDTH-1] ? (~q_in + DATA_WIDTH'(1)) : q_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_abs_i <= '0;
      r_abs_q <= '0;
    end else if (s1_en_in) begin
      r_abs_i <= w_abs_i;
      r_abs_q <= w_abs_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_max <= '0;
      r_min <= '0;
    end else if (s2_en_in) begin
      r_max <= (r_abs_i >= r_abs_q) ? r_abs_i : r_abs_q;
      r_min <= (r_abs_i >= r_abs_q) ? r_abs_q : r_abs_i;
    end
  end

  assign w_max     = {1'b0, r_max};
  assign w_min     = {1'b0, r_min};
  assign w_q4      = w_max + (w_min >> 2);
  assign w_q38     = w_q4 + (w_min >> 3);
  assign w_acc     = w_max - (w_max >> 3) + (w_min >> 1);
  assign w_acc_sel = (w_acc > w_max) ? w_acc : w_max;

  always_comb begin
    w_mag = w_q4;
    case (mag_mode_e'(mode_in))
      MAG_MODE_Q38: w_mag = w_q38;
      MAG_MODE_ACC: w_mag = w_acc_sel;
      default:      w_mag = w_q4;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_mag <= '0;
    end else if (s3_en_in) begin
      r_mag <= w_mag;
    end
  end

  assign mag_out = r_mag;

endmodule

// File: rtl/complex_to_mag_axis.sv
// NUM_CH-lane IQ magnitude stage with AXI-Stream handshake and tlast passthrough.
// Optional per-lane frame peak tracking under `COMPLEX_TO_MAG_PEAK_TRACK_EN.
module complex_to_mag_axis
  import complex_to_mag_pkg::*;
#(
  parameter int DATA_WIDTH = MAG_DEFAULT_DATA_WIDTH,
  parameter int NUM_CH     = MAG_DEFAULT_NUM_CH
) (
  input  logic                              clk_in,
  input  logic                              rst_n_in,
  input  logic [1:0]                        mode_in,
  input  logic [NUM_CH*2*DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [NUM_CH*(DATA_WIDTH+1)-1:0]  m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [NUM_CH*(DATA_WIDTH+1)-1:0]  peak_out,
  output logic                              peak_valid_out
);

  localparam int OW = DATA_WIDTH + 1;

  // Handshake: a beat moves on a rising edge where valid && ready. Each stage
  // loads when it is empty or the stage after it loads, so bubbles collapse
  // and s_axis_tready is combinational from m_axis_tready along that chain.
  logic    r_v1, r_v2, r_v3;
  logic    w_en1, w_en2, w_en3;
  mag_sb_t r_sb1, r_sb2;
  logic    r_last3;
  logic [OW-1:0] w_mag [NUM_CH];

  assign w_en3         = !r_v3 || m_axis_tready;
  assign w_en2         = !r_v2 || w_en3;
  assign w_en1         = !r_v1 || w_en2;
  assign s_axis_tready = w_en1;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else begin
      if (w_en1) r_v1 <= s_axis_tvalid;
      if (w_en2) r_v2 <= r_v1;
      if (w_en3) r_v3 <= r_v2;
    end
  end

  // Mode travels with its beat so a change only affects later beats.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_sb1   <= '0;
      r_sb2   <= '0;
      r_last3 <= 1'b0;
    end else begin
      if (w_en1 && s_axis_tvalid) r_sb1   <= '{mode: mag_mode_e'(mode_in), last: s_axis_tlast};
      if (w_en2 && r_v1)          r_sb2   <= r_sb1;
      if (w_en3 && r_v2)          r_last3 <= r_sb2.last;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    complex_to_mag_lane #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .s1_en_in (w_en1 && s_axis_tvalid),
      .s2_en_in (w_en2 && r_v1),
      .s3_en_in (w_en3 && r_v2),
      .i_in     (s_axis_tdata[k*2*DATA_WIDTH +: DATA_WIDTH]),
      .q_in     (s_axis_tdata[k*2*DATA_WIDTH+DATA_WIDTH +: DATA_WIDTH]),
      .mode_in  (r_sb2.mode),
      .mag_out  (w_mag[k])
    );
    assign m_axis_tdata[k*OW +: OW] = w_mag[k];
  end

  assign m_axis_tvalid = r_v3;
  assign m_axis_tlast  = r_last3;

`ifdef COMPLEX_TO_MAG_PEAK_TRACK_EN
  logic w_hs;
  logic r_peak_valid;

  assign w_hs = r_v3 && m_axis_tready;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_peak
    logic [OW-1:0] r_run, r_peak, w_hi;

    assign w_hi = (r_run > w_mag[k]) ? r_run : w_mag[k];

    // The closing beat is folded into the reported peak, then the frame restarts.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        r_run  <= '0;
        r_peak <= '0;
      end else if (w_hs) begin
        if (r_last3) begin
          r_peak <= w_hi;
          r_run  <= '0;
        end else begin
          r_run  <= w_hi;
        end
      end
    end

    assign peak_out[k*OW +: OW] = r_peak;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_peak_valid <= 1'b0;
    else           r_peak_valid <= w_hs && r_last3;
  end

  assign peak_valid_out = r_peak_valid;
`else
  assign peak_out       = '0;
  assign peak_valid_out = 1'b0;
`endif

endmodule

// File: tb/tb_complex_to_mag_axis.sv
// Directed bench for complex_to_mag_axis (DATA_WIDTH=16, NUM_CH=4); peak checks
// follow `COMPLEX_TO_MAG_PEAK_TRACK_EN.
module tb_complex_to_mag_axis;

  localparam int DW  = 16;
  localparam int NCH = 4;
  localparam int OW  = DW + 1;
  localparam int IW  = NCH * 2 * DW;
  localparam int MW  = NCH * OW;
  localparam int NV  = 14;

  typedef struct {
    logic [DW-1:0] i;
    logic [DW-1:0] q;
    logic [1:0]    mode;
    logic [OW-1:0] exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    mode;
  logic [IW-1:0] s_tdata;
  logic          s_tvalid, s_tready, s_tlast;
  logic [MW-1:0] m_tdata, peak;
  logic          m_tvalid, m_tready, m_tlast, peak_valid;

  complex_to_mag_axis #(.DATA_WIDTH(DW), .NUM_CH(NCH)) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .mode_in        (mode),
    .s_axis_tdata   (s_tdata),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tready  (s_tready),
    .s_axis_tlast   (s_tlast),
    .m_axis_tdata   (m_tdata),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tready  (m_tready),
    .m_axis_tlast   (m_tlast),
    .peak_out       (peak),
    .peak_valid_out (peak_valid)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [MW:0] exp_q[$];
  logic [MW:0] obs_q[$];
  int          obs_cyc[$];
  logic [MW-1:0] pk_q[$];
  int obs_rd = 0;
  int n_acc  = 0;
  int n_tests = 0;
  int n_fail  = 0;
  int hold_err = 0;
  logic        prev_stall = 1'b0;
  logic [MW:0] prev_beat;
  vec_t vecs[NV];

  // output monitor: records handshakes, stall stability and peak pulses
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall && !(m_tvalid && {m_tlast, m_tdata} == prev_beat)) hold_err++;
      if (m_tvalid && m_tready) begin
        obs_q.push_back({m_tlast, m_tdata});
        obs_cyc.push_back(cyc);
      end
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = {m_tlast, m_tdata};
      if (peak_valid) pk_q.push_back(peak);
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] bcast_in(input logic [DW-1:0] i, input logic [DW-1:0] q);
    logic [IW-1:0] d;
    for (int k = 0; k < NCH; k++) d[k*2*DW +: 2*DW] = {q, i};
    return d;
  endfunction

  function automatic logic [MW-1:0] bcast_out(input logic [OW-1:0] e);
    logic [MW-1:0] d;
    for (int k = 0; k < NCH; k++) d[k*OW +: OW] = e;
    return d;
  endfunction

  // driver: present a beat and hold it until accepted
  task automatic send(input logic [IW-1:0] d, input logic [1:0] m, input logic l,
                      input logic [MW-1:0] e);
    int   guard = 0;
    logic acc = 1'b0;
    s_tdata = d; mode = m; s_tlast = l; s_tvalid = 1'b1;
    while (!acc && guard < 100) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk); #1;
      guard++;
    end
    s_tvalid = 1'b0;
    n_tests++;
    if (!acc) begin
      n_fail++;
      $display("FAIL send_accept: got not accepted expected accepted within 100 cycles");
    end else begin
      exp_q.push_back({l, e});
      n_acc++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input string name);
    int guard = 0;
    while ((obs_q.size() - obs_rd) < exp_q.size() && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check({name, "_timeout"}, 128'((obs_q.size() - obs_rd) >= exp_q.size()), 128'd1);
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      check(name, 128'(obs_q[obs_rd]), 128'(exp_q.pop_front()));
      obs_rd++;
    end
    exp_q.delete();
    idle(3);
    check({name, "_extra"}, 128'(obs_q.size() - obs_rd), 128'd0);
    obs_rd = obs_q.size();
  endtask

  initial begin : main
    int t0, ob0, pk0, acc0;
    logic [IW-1:0] d;
    logic [MW-1:0] e;

    vecs[0]  = '{16'd3,     16'hFFFC, 2'd0, 17'd4};
    vecs[1]  = '{16'h8000,  16'd0,    2'd0, 17'd32768};
    vecs[2]  = '{16'd100,   16'd100,  2'd0, 17'd125};
    vecs[3]  = '{16'd100,   16'd100,  2'd1, 17'd137};
    vecs[4]  = '{16'd100,   16'd100,  2'd2, 17'd138};
    vecs[5]  = '{16'd100,   16'd100,  2'd3, 17'd125};
    vecs[6]  = '{16'd0,     16'd0,    2'd0, 17'd0};
    vecs[7]  = '{16'h8000,  16'h8000, 2'd1, 17'd45056};
    vecs[8]  = '{16'h8000,  16'h8000, 2'd2, 17'd45056};
    vecs[9]  = '{16'd32767, 16'd0,    2'd2, 17'd32767};
    vecs[10] = '{16'hFFFB,  16'd12,   2'd1, 17'd13};
    vecs[11] = '{16'd7,     16'hFFFF, 2'd2, 17'd7};
    vecs[12] = '{16'd8,     16'd8,    2'd2, 17'd11};
    vecs[13] = '{16'd1000,  16'hFF38, 2'd1, 17'd1075};

    rst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; mode = 2'd0; m_tready = 1'b1;
    idle(3);
    check("rst_tvalid", 128'(m_tvalid), 128'd0);
    check("rst_tdata",  128'(m_tdata),  128'd0);
    check("rst_tlast",  128'(m_tlast),  128'd0);
    check("rst_peak",   128'(peak),     128'd0);
    check("rst_peak_v", 128'(peak_valid), 128'd0);
    rst_n = 1'b1;
    idle(1);
    check("rst_tready", 128'(s_tready), 128'd1);

    // table: single-beat frames, broadcast to all lanes, latency measured
    for (int v = 0; v < NV; v++) begin
      ob0 = obs_q.size();
      t0  = cyc;
      send(bcast_in(vecs[v].i, vecs[v].q), vecs[v].mode, 1'b1, bcast_out(vecs[v].exp));
      drain($sformatf("vec%0d", v));
      check($sformatf("vec%0d_latency", v),
            128'((obs_cyc.size() > ob0) ? obs_cyc[ob0] - t0 : -1), 128'd3);
    end

    // distinct values per lane in one beat
    d = {16'd0, 16'd0, 16'd100, 16'd100, 16'd0, 16'h8000, 16'hFFFC, 16'd3};
    e = {17'd0, 17'd125, 17'd32768, 17'd4};
    send(d, 2'd0, 1'b1, e);
    drain("lanes");

    // mode switches beat by beat
    for (int m = 0; m < 4; m++)
      send(bcast_in(16'd100, 16'd100), 2'(m), 1'b1, bcast_out(vecs[2 + m].exp));
    drain("mode_seq");

    // backpressure: tready low for cycles 2..6
    acc0 = n_acc;
    fork
      begin
        for (int k = 0; k < 8; k++)
          send(bcast_in(vecs[k].i, vecs[k].q), vecs[k].mode, k == 7, bcast_out(vecs[k].exp));
      end
      begin
        idle(2);
        m_tready = 1'b0;
        idle(4);
        check("bp_tready_low", 128'(s_tready), 128'd0);
        check("bp_held_beats", 128'(n_acc - acc0), 128'd3);
        check("bp_tvalid_held", 128'(m_tvalid), 128'd1);
        idle(1);
        m_tready = 1'b1;
      end
    join
    drain("bp");
    check("bp_hold_stable", 128'(hold_err), 128'd0);

    // throughput: 16 back-to-back beats
    ob0 = obs_q.size();
    t0  = cyc;
    for (int k = 0; k < 16; k++)
      send(bcast_in(vecs[k % NV].i, vecs[k % NV].q), vecs[k % NV].mode, k == 15,
           bcast_out(vecs[k % NV].exp));
    check("tp_accept_cycles", 128'(cyc - t0), 128'd16);
    drain("tp");
    check("tp_first", 128'((obs_cyc.size() > ob0) ? obs_cyc[ob0] - t0 : -1), 128'd3);
    check("tp_span", 128'((obs_cyc.size() > ob0 + 15) ? obs_cyc[ob0 + 15] - obs_cyc[ob0] : -1), 128'd15);

    // reset with beats in flight
    for (int k = 0; k < 3; k++)
      send(bcast_in(16'd100, 16'd100), 2'd0, 1'b0, bcast_out(17'd125));
    rst_n = 1'b0;
    #1;
    check("mid_rst_tvalid", 128'(m_tvalid), 128'd0);
    check("mid_rst_tdata",  128'(m_tdata),  128'd0);
    exp_q.delete();
    obs_rd = obs_q.size();
    idle(2);
    rst_n = 1'b1;
    idle(8);
    check("mid_rst_no_stale", 128'(obs_q.size() - obs_rd), 128'd0);
    check("mid_rst_tvalid_after", 128'(m_tvalid), 128'd0);

`ifdef COMPLEX_TO_MAG_PEAK_TRACK_EN
    // lane-0 frame 10,50,20,30 then a one-beat frame of 5
    pk0 = pk_q.size();
    send({112'd0, 16'd10}, 2'd0, 1'b0, {51'd0, 17'd10});
    send({112'd0, 16'd50}, 2'd0, 1'b0, {51'd0, 17'd50});
    send({112'd0, 16'd20}, 2'd0, 1'b0, {51'd0, 17'd20});
    send({112'd0, 16'd30}, 2'd0, 1'b1, {51'd0, 17'd30});
    drain("peak_f1");
    check("peak_f1_pulses", 128'(pk_q.size() - pk0), 128'd1);
    check("peak_f1_value", 128'((pk_q.size() > pk0) ? pk_q[pk0] : '1), 128'({51'd0, 17'd50}));
    pk0 = pk_q.size();
    send({112'd0, 16'd5}, 2'd0, 1'b1, {51'd0, 17'd5});
    drain("peak_f2");
    check("peak_f2_pulses", 128'(pk_q.size() - pk0), 128'd1);
    check("peak_f2_value", 128'((pk_q.size() > pk0) ? pk_q[pk0] : '1), 128'({51'd0, 17'd5}));
    check("peak_hold", 128'(peak), 128'({51'd0, 17'd5}));
`else
    check("peak_never_pulsed", 128'(pk_q.size()), 128'd0);
    check("peak_tied_zero", 128'(peak), 128'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
